// File: rtl/cd_irq_csr.sv
// Interrupt/status CSR block: per-event level or sticky-edge flags, polarity, mask,
// W1C clear, saturating event counter and an irq holdoff (coalescing) timer.
module cd_irq_csr #(
  parameter int unsigned N_EVT   = 16,
  parameter int unsigned HOLD_W  = 16,
  parameter logic [7:0]  VERSION = 8'h10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       csr_address,
  input  logic             csr_read,
  output logic [31:0]      csr_readdata,
  input  logic             csr_write,
  input  logic [31:0]      csr_writedata,
  input  logic [3:0]       csr_byteenable,
  input  logic [N_EVT-1:0] evt_in,
  output logic             irq
);

  typedef enum logic [1:0] {StIdle, StAssert, StHold} state_e;

  localparam logic [3:0] AddrId     = 4'h0;
  localparam logic [3:0] AddrMode   = 4'h1;
  localparam logic [3:0] AddrPol    = 4'h2;
  localparam logic [3:0] AddrMask   = 4'h3;
  localparam logic [3:0] AddrFlag   = 4'h4;
  localparam logic [3:0] AddrPend   = 4'h5;
  localparam logic [3:0] AddrHold   = 4'h6;
  localparam logic [3:0] AddrEvtCnt = 4'h7;
  localparam logic [3:0] AddrCtrl   = 4'h8;

  logic [N_EVT-1:0]  mode_q, mode_d;
  logic [N_EVT-1:0]  pol_q, pol_d;
  logic [N_EVT-1:0]  mask_q, mask_d;
  logic [N_EVT-1:0]  sticky_q, sticky_d;
  logic [N_EVT-1:0]  evt_d_q, evt_d_d;
  logic [HOLD_W-1:0] holdoff_q, holdoff_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [7:0]        evt_cnt_q, evt_cnt_d;
  state_e            state_q, state_d;
  logic              irq_q, irq_d;

  logic [31:0]       wr_mask;
  logic [N_EVT-1:0]  wr_evt_mask, wr_evt_data;
  logic [HOLD_W-1:0] wr_hold_mask, wr_hold_data;
  logic [N_EVT-1:0]  e, rise, flag, pend, clr;
  logic              pend_any, ctrl_clr, cnt_rd;

  // Byte-lane write mask, narrowed to each register's implemented width.
  assign wr_mask      = {{8{csr_byteenable[3]}}, {8{csr_byteenable[2]}},
                         {8{csr_byteenable[1]}}, {8{csr_byteenable[0]}}};
  assign wr_evt_mask  = N_EVT'(wr_mask);
  assign wr_evt_data  = N_EVT'(csr_writedata & wr_mask);
  assign wr_hold_mask = HOLD_W'(wr_mask);
  assign wr_hold_data = HOLD_W'(csr_writedata & wr_mask);

  assign e        = evt_in ^ pol_q;
  assign rise     = e & ~evt_d_q & mode_q;
  assign flag     = (mode_q & sticky_q) | (~mode_q & e);
  assign pend     = flag & mask_q;
  assign pend_any = |pend;
  assign ctrl_clr = csr_write && (csr_address == AddrCtrl) && csr_byteenable[0] &&
                    csr_writedata[0];
  assign cnt_rd   = csr_read && (csr_address == AddrEvtCnt);

  always_comb begin
    mode_d    = mode_q;
    pol_d     = pol_q;
    mask_d    = mask_q;
    holdoff_d = holdoff_q;
    clr       = {N_EVT{ctrl_clr}};
    if (csr_write) begin
      unique case (csr_address)
        AddrMode: mode_d    = (mode_q & ~wr_evt_mask) | wr_evt_data;
        AddrPol:  pol_d     = (pol_q & ~wr_evt_mask) | wr_evt_data;
        AddrMask: mask_d    = (mask_q & ~wr_evt_mask) | wr_evt_data;
        AddrFlag: clr       = wr_evt_data;
        AddrHold: holdoff_d = (holdoff_q & ~wr_hold_mask) | wr_hold_data;
        default:  ;
      endcase
    end
    // Set beats clear; switching a bit to level mode drops its sticky storage.
    sticky_d = ((sticky_q & ~clr) | rise) & mode_d;
    // Track the post-write polarity so a POL change never looks like an edge.
    evt_d_d  = evt_in ^ pol_d;
  end

  always_comb begin
    evt_cnt_d = evt_cnt_q;
    if (cnt_rd) begin
      evt_cnt_d = (|rise) ? 8'd1 : 8'd0;
    end else if ((|rise) && (evt_cnt_q != 8'hFF)) begin
      evt_cnt_d = evt_cnt_q + 8'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pend_any) state_d = StAssert;
      end
      StAssert: begin
        if (!pend_any) begin
          if (holdoff_q != '0) begin
            state_d    = StHold;
            hold_cnt_d = holdoff_q - HOLD_W'(1);
          end else begin
            state_d = StIdle;
          end
        end
      end
      StHold: begin
        if (hold_cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    irq_d = (state_d == StAssert);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q     <= '0;
      pol_q      <= '0;
      mask_q     <= '0;
      sticky_q   <= '0;
      evt_d_q    <= '0;
      holdoff_q  <= '0;
      hold_cnt_q <= '0;
      evt_cnt_q  <= '0;
      state_q    <= StIdle;
      irq_q      <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      pol_q      <= pol_d;
      mask_q     <= mask_d;
      sticky_q   <= sticky_d;
      evt_d_q    <= evt_d_d;
      holdoff_q  <= holdoff_d;
      hold_cnt_q <= hold_cnt_d;
      evt_cnt_q  <= evt_cnt_d;
      state_q    <= state_d;
      irq_q      <= irq_d;
    end
  end

  assign irq = irq_q;

  always_comb begin
    csr_readdata = 32'd0;
    unique case (csr_address)
      AddrId:     csr_readdata = {8'd0, 8'(N_EVT), 8'd0, VERSION};
      AddrMode:   csr_readdata = 32'(mode_q);
      AddrPol:    csr_readdata = 32'(pol_q);
      AddrMask:   csr_readdata = 32'(mask_q);
      AddrFlag:   csr_readdata = 32'(flag);
      AddrPend:   csr_readdata = 32'(pend);
      AddrHold:   csr_readdata = 32'(holdoff_q);
      AddrEvtCnt: csr_readdata = 32'(evt_cnt_q);
      default:    csr_readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cd_irq_csr.sv
// Scoreboard bench for cd_irq_csr: driver pushes model expectations, a negedge monitor
// pops and compares irq every cycle and read data on read cycles.
module tb_cd_irq_csr;

  localparam logic [31:0] EM = 32'h0000_FFFF;
  localparam logic [31:0] HM = 32'h0000_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  csr_address = '0;
  logic        csr_read = 1'b0;
  logic [31:0] csr_readdata;
  logic        csr_write = 1'b0;
  logic [31:0] csr_writedata = '0;
  logic [3:0]  csr_byteenable = '0;
  logic [15:0] evt_in = '0;
  logic        irq;

  cd_irq_csr dut (
    .clk            (clk),
    .reset          (reset),
    .csr_address    (csr_address),
    .csr_read       (csr_read),
    .csr_readdata   (csr_readdata),
    .csr_write      (csr_write),
    .csr_writedata  (csr_writedata),
    .csr_byteenable (csr_byteenable),
    .evt_in         (evt_in),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_rd;
    logic [3:0]  a;
    logic [31:0] rdata;
    logic        irq;
  } exp_t;

  exp_t q[$];
  int   vecs = 0;
  int   miss = 0;

  // Reference model: plain registers plus an irq phase (0 idle, 1 asserted, 2 holdoff).
  logic [31:0] ev_cur;
  logic [31:0] m_mode, m_pol, m_mask, m_sticky, m_prev_e, m_hold;
  int          m_cnt, m_phase, m_left;
  logic        m_irq;

  task automatic m_reset();
    m_mode = 0; m_pol = 0; m_mask = 0; m_sticky = 0; m_prev_e = 0; m_hold = 0;
    m_cnt = 0; m_phase = 0; m_left = 0; m_irq = 0;
  endtask

  function automatic logic [31:0] m_flag();
    logic [31:0] e, f;
    e = (ev_cur ^ m_pol) & EM;
    f = 0;
    for (int i = 0; i < 16; i++) f[i] = m_mode[i] ? m_sticky[i] : e[i];
    return f;
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] a);
    case (a)
      4'h0: return 32'h0010_0010;
      4'h1: return m_mode;
      4'h2: return m_pol;
      4'h3: return m_mask;
      4'h4: return m_flag();
      4'h5: return m_flag() & m_mask;
      4'h6: return m_hold;
      4'h7: return 32'(m_cnt);
      default: return 0;
    endcase
  endfunction

  task automatic m_step(input logic [3:0] a, input bit rd, input bit wr,
                        input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] e, rise, bm, clr, n_mode, n_pol;
    bit pend;
    e    = (ev_cur ^ m_pol) & EM;
    rise = e & ~m_prev_e & m_mode;
    pend = (m_flag() & m_mask) != 0;
    if (m_phase == 0) begin
      if (pend) m_phase = 1;
    end else if (m_phase == 1) begin
      if (!pend) begin
        if (m_hold != 0) begin m_phase = 2; m_left = int'(m_hold) - 1; end
        else m_phase = 0;
      end
    end else begin
      if (m_left == 0) m_phase = 0;
      else m_left--;
    end
    m_irq = (m_phase == 1);
    if (rd && a == 4'h7) m_cnt = (rise != 0) ? 1 : 0;
    else if (rise != 0 && m_cnt < 255) m_cnt++;
    bm = 0;
    for (int b = 0; b < 4; b++) if (be[b]) bm[b*8 +: 8] = 8'hFF;
    n_mode = m_mode; n_pol = m_pol; clr = 0;
    if (wr) begin
      if (a == 4'h1) n_mode = ((m_mode & ~bm) | (wd & bm)) & EM;
      if (a == 4'h2) n_pol  = ((m_pol & ~bm) | (wd & bm)) & EM;
      if (a == 4'h3) m_mask = ((m_mask & ~bm) | (wd & bm)) & EM;
      if (a == 4'h6) m_hold = ((m_hold & ~bm) | (wd & bm)) & HM;
      if (a == 4'h4) clr = wd & bm & EM;
      if (a == 4'h8 && be[0] && wd[0]) clr = EM;
    end
    m_sticky = ((m_sticky & ~clr) | rise) & n_mode;
    m_mode   = n_mode;
    m_pol    = n_pol;
    m_prev_e = (ev_cur ^ m_pol) & EM;
  endtask

  task automatic cyc(input logic [3:0] a, input bit rd, input bit wr, input logic [31:0] wd,
                     input logic [3:0] be, input bit use_c, input logic [31:0] cval);
    exp_t x;
    csr_address = a; csr_read = rd; csr_write = wr; csr_writedata = wd;
    csr_byteenable = be; evt_in = ev_cur[15:0];
    x.is_rd = rd; x.a = a; x.rdata = use_c ? cval : m_read(a); x.irq = m_irq;
    q.push_back(x);
    @(posedge clk);
    m_step(a, rd, wr, wd, be);
    #1;
    csr_read = 1'b0; csr_write = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    cyc(a, 0, 1, d, 4'hF, 0, 0);
  endtask
  task automatic rd(input logic [3:0] a);
    cyc(a, 1, 0, 0, 4'h0, 0, 0);
  endtask
  task automatic rdc(input logic [3:0] a, input logic [31:0] v);
    cyc(a, 1, 0, 0, 4'h0, 1, v);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(4'hF, 0, 0, 0, 4'h0, 0, 0);
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      vecs++;
      if (irq !== x.irq) begin
        miss++;
        $display("FAIL irq @%0t: got %b expected %b", $time, irq, x.irq);
      end
      if (x.is_rd) begin
        vecs++;
        if (csr_readdata !== x.rdata) begin
          miss++;
          $display("FAIL read[%0h] @%0t: got %h expected %h", x.a, $time, csr_readdata,
                   x.rdata);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ev_cur = 0;
    m_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset values
    rdc(4'h0, 32'h0010_0010);
    for (int a = 1; a < 16; a++) rdc(4'(a), 32'd0);

    // Level mode on bit 0
    wr(4'h3, 32'h1);
    ev_cur = 32'h1; idle(3);
    ev_cur = 32'h0; idle(2);
    rdc(4'h4, 32'd0);

    // Sticky edge on bit 3 with W1C colliding with a new rise
    wr(4'h1, 32'h8);
    ev_cur = 32'h8; idle(1);
    ev_cur = 32'h0; idle(1);
    rdc(4'h4, 32'h8);
    ev_cur = 32'h8; wr(4'h4, 32'h8);
    ev_cur = 32'h0; idle(1);
    rdc(4'h4, 32'h8);
    rdc(4'h7, 32'd2);

    // Holdoff coalescing
    wr(4'h4, 32'h8);
    wr(4'h6, 32'd5);
    wr(4'h3, 32'h8);
    ev_cur = 32'h8; idle(1);
    ev_cur = 32'h0; idle(2);
    wr(4'h4, 32'h8);
    ev_cur = 32'h8; idle(1);
    ev_cur = 32'h0; idle(10);
    wr(4'h8, 32'h1);
    idle(8);

    // Counter saturation
    wr(4'h6, 32'd0);
    wr(4'h3, 32'h0);
    wr(4'h1, 32'h1);
    rd(4'h7);
    for (int i = 0; i < 300; i++) begin
      ev_cur = 32'h1; idle(1);
      ev_cur = 32'h0; idle(1);
    end
    rdc(4'h7, 32'd255);
    rdc(4'h7, 32'd0);

    // Byte-enabled MASK write, then async reset with irq high
    wr(4'h1, 32'h0);
    cyc(4'h3, 0, 1, 32'hFFFF_FFFF, 4'b0010, 0, 0);
    rdc(4'h3, 32'h0000_FF00);
    ev_cur = 32'h100; idle(3);
    vecs++;
    if (irq !== 1'b1) begin
      miss++;
      $display("FAIL irq_before_reset: got %b expected 1", irq);
    end
    csr_address = 4'h3;
    #2 reset = 1'b1;
    #1;
    vecs++;
    if (irq !== 1'b0) begin
      miss++;
      $display("FAIL async_reset_irq: got %b expected 0", irq);
    end
    vecs++;
    if (csr_readdata !== 32'd0) begin
      miss++;
      $display("FAIL async_reset_mask: got %h expected 00000000", csr_readdata);
    end
    m_reset();
    ev_cur = 0;
    evt_in = '0;
    @(posedge clk);
    #1 reset = 1'b0;

    // Randomised traffic
    for (int i = 0; i < 2500; i++) begin
      logic [3:0]  a;
      logic [31:0] wd;
      int          op;
      if ($urandom_range(0, 5) == 0) ev_cur = ev_cur ^ (32'h1 << $urandom_range(0, 15));
      a  = 4'($urandom_range(0, 15));
      wd = $urandom;
      if (a == 4'h6) wd = 32'($urandom_range(0, 12));
      if (a == 4'h8 && $urandom_range(0, 3) != 0) wd[0] = 1'b0;
      op = $urandom_range(0, 5);
      cyc(a, op < 3 || op == 5, op >= 3, wd, 4'($urandom_range(0, 15)), 0, 0);
    end

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
